// File: rtl/uart_pkg.sv
// Shared UART constants for the deframer, Rx buffer and Tx path.
package uart_pkg;
  localparam int UART_DATA_W          = 8;
  localparam int UART_FIFO_DEPTH_LOG2 = 4;
  localparam int UART_ERR_CNT_W       = 8;
endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage for the Rx FIFO: one write port, one registered read port.
module uart_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  // Read returns the old word when the same address is written in the same cycle.
  always_comb begin
    rd_data_d = rd_data_q;
    if (i_re) rd_data_d = mem[i_raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign o_rdata = rd_data_q;
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: stores good frames, drops and counts errored frames, host pops with i_rd_en.
// Optional almost-full output enabled by defining UART_RX_FIFO_ALMOST_FULL_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2,
  parameter int AF_THRESH  = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         i_rx_d,
  input  logic                      i_rx_complete,
  input  logic                      i_rx_error,
  input  logic                      i_rd_en,
  input  logic                      i_clr_flags,
  output logic [DATA_W-1:0]         o_rd_data,
  output logic                      o_rd_valid,
  output logic                      o_empty,
  output logic                      o_full,
  output logic [DEPTH_LOG2:0]       o_count,
  output logic                      o_overflow,
  output logic                      o_underflow,
  output logic [UART_ERR_CNT_W-1:0] o_err_cnt,
  output logic                      o_almost_full
);
  localparam int PTR_W = DEPTH_LOG2 + 1;

  if (DEPTH_LOG2 < 2 || DEPTH_LOG2 > 8 || AF_THRESH < 1 || AF_THRESH > 2**DEPTH_LOG2) begin : g_param_check
    $error("uart_rx_fifo: illegal DEPTH_LOG2 or AF_THRESH");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic empty_q, empty_d, full_q, full_d;
  logic overflow_q, overflow_d, underflow_q, underflow_d, rd_valid_q, rd_valid_d;
  logic [UART_ERR_CNT_W-1:0] err_cnt_q, err_cnt_d, err_base;
  logic wr_req, wr_ok, pop_ok;

  // An error pulse always wins over a coincident complete pulse; a pop frees the slot for a write when full.
  always_comb begin
    wr_req   = i_rx_complete & ~i_rx_error;
    pop_ok   = i_rd_en & ~empty_q;
    wr_ok    = wr_req & (~full_q | pop_ok);
    wr_ptr_d = wr_ok  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({wr_ok, pop_ok})
      2'b10:   count_d = count_q + PTR_W'(1);
      2'b01:   count_d = count_q - PTR_W'(1);
      default: count_d = count_q;
    endcase
    empty_d     = (wr_ptr_d == rd_ptr_d);
    full_d      = (wr_ptr_d[PTR_W-1] != rd_ptr_d[PTR_W-1]) &&
                  (wr_ptr_d[PTR_W-2:0] == rd_ptr_d[PTR_W-2:0]);
    overflow_d  = (wr_req & full_q & ~pop_ok) | (overflow_q & ~i_clr_flags);
    underflow_d = (i_rd_en & empty_q) | (underflow_q & ~i_clr_flags);
    err_base    = i_clr_flags ? '0 : err_cnt_q;
    err_cnt_d   = err_base;
    if (i_rx_error && err_base != '1) err_cnt_d = err_base + UART_ERR_CNT_W'(1);
    rd_valid_d  = pop_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      err_cnt_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      err_cnt_q   <= err_cnt_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  uart_fifo_mem #(.DATA_W(DATA_W), .ADDR_W(DEPTH_LOG2)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (wr_ok),
    .i_waddr (wr_ptr_q[DEPTH_LOG2-1:0]),
    .i_wdata (i_rx_d),
    .i_re    (pop_ok),
    .i_raddr (rd_ptr_q[DEPTH_LOG2-1:0]),
    .o_rdata (o_rd_data)
  );

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  logic almost_full_q, almost_full_d;

  always_comb almost_full_d = (count_d >= PTR_W'(AF_THRESH));

  always_ff @(posedge clk) begin
    if (rst) almost_full_q <= 1'b0;
    else     almost_full_q <= almost_full_d;
  end

  assign o_almost_full = almost_full_q;
`else
  assign o_almost_full = 1'b0;
`endif

  assign o_rd_valid  = rd_valid_q;
  assign o_empty     = empty_q;
  assign o_full      = full_q;
  assign o_count     = count_q;
  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;
  assign o_err_cnt   = err_cnt_q;
endmodule
